// File: rtl/cskipa_pkg.sv
// Shared types and constants for the carry-skip adder feed/accumulate stage.
// Holds the FSM encoding and the {cout,sum} result tuple returned by the adder slice.
package cskipa_pkg;

  localparam int ADD_W = 6;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EVAL   = 2'd1,
    OUT    = 2'd2
  } state_e;

  typedef struct packed {
    logic             cout;
    logic [ADD_W-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/cskipa_acc_reg.sv
// Frame accumulator: wrapping total, saturating pair count, sticky overflow flag.
// clr takes priority over add_en so a frame result is released cleanly.
module cskipa_acc_reg
  import cskipa_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clr,
  input  logic [ADD_W:0]   din,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;
  logic             count_sat;

  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W-ADD_W){1'b0}}, din};
  assign count_sat = &count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (add_en) begin
      acc_d   = sum_ext[ACC_W-1:0];
      count_d = count_sat ? count_q : count_q + CNT_W'(1);
      ovf_d   = ovf_q | sum_ext[ACC_W] | count_sat;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc   = acc_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/cskipa_result_accum.sv
// Operand feed and result accumulation around an external 6-bit carry-skip adder.
// Handshake readies/valids decode from registered state only, so no input-to-ready paths exist.
module cskipa_result_accum
  import cskipa_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_a,
  input  logic [ADD_W-1:0] in_b,
  input  logic             in_last,
  output logic [ADD_W-1:0] o_add_term1,
  output logic [ADD_W-1:0] o_add_term2,
  input  logic [ADD_W-1:0] i_sum,
  input  logic             i_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  if (ACC_W < ADD_W + 1) begin : g_bad_acc_w
    $error("cskipa_result_accum: ACC_W must be at least ADD_W+1");
  end

  state_e           state_q, state_d;
  logic [ADD_W-1:0] term1_q, term1_d;
  logic [ADD_W-1:0] term2_q, term2_d;
  logic             last_q, last_d;
  add_res_t         add_res;

  assign add_res = '{cout: i_cout, sum: i_sum};

  always_comb begin
    state_d = state_q;
    term1_d = term1_q;
    term2_d = term2_q;
    last_d  = last_q;
    case (state_q)
      ACCEPT: begin
        if (in_valid) begin
          term1_d = in_a;
          term2_d = in_b;
          last_d  = in_last;
          state_d = EVAL;
        end
      end
      EVAL:    state_d = last_q ? OUT : ACCEPT;
      OUT:     if (out_ready) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      term1_q <= '0;
      term2_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term1_q <= term1_d;
      term2_q <= term2_d;
      last_q  <= last_d;
    end
  end

  // The adder output is only sampled in EVAL, one cycle after the terms were registered.
  cskipa_acc_reg #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_acc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .add_en(state_q == EVAL),
    .clr   ((state_q == OUT) && out_ready),
    .din   (add_res),
    .acc   (out_total),
    .count (out_count),
    .ovf   (out_ovf)
  );

  assign in_ready    = (state_q == ACCEPT);
  assign out_valid   = (state_q == OUT);
  assign o_add_term1 = term1_q;
  assign o_add_term2 = term2_q;

endmodule

// File: tb/tb_cskipa_result_accum.sv
// Directed and randomized bench for cskipa_result_accum with a behavioural adder and frame model.
module tb_cskipa_result_accum;
  import cskipa_pkg::*;

  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [ADD_W-1:0] in_a, in_b;
  logic [ADD_W-1:0] o_add_term1, o_add_term2, i_sum;
  logic             i_cout;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic [ADD_W:0]   add_res;

  int n_checks = 0;
  int n_err    = 0;
  int m_sum    = 0;
  int m_pairs  = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external carry-skip adder slice.
  assign add_res         = {1'b0, o_add_term1} + {1'b0, o_add_term2};
  assign {i_cout, i_sum} = add_res;

  cskipa_result_accum #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .o_add_term1(o_add_term1),
    .o_add_term2(o_add_term2),
    .i_sum      (i_sum),
    .i_cout     (i_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_total  (out_total),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one pair, waits for acceptance, then checks the EVAL cycle (and OUT latency on last).
  task automatic send_pair(input int a, input int b, input bit last);
    int w;
    @(negedge clk);
    in_a     = ADD_W'(a);
    in_b     = ADD_W'(b);
    in_last  = last;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_sum   += a + b;
    m_pairs++;
    @(negedge clk);
    check("eval_in_ready", 32'(in_ready), 32'd0);
    check("eval_out_valid", 32'(out_valid), 32'd0);
    check("term1", 32'(o_add_term1), 32'(a));
    check("term2", 32'(o_add_term2), 32'(b));
    if (last) begin
      @(negedge clk);
      check("out_latency", 32'(out_valid), 32'd1);
    end
  endtask

  // Waits for the frame result, checks it against the model, optionally stalls, then consumes it.
  task automatic collect(input int hold, input bit poke_in);
    int w;
    int exp_total, exp_count, exp_ovf;
    exp_total = m_sum % (1 << ACC_W);
    exp_count = (m_pairs > CNT_MAX) ? CNT_MAX : m_pairs;
    exp_ovf   = (m_sum >= (1 << ACC_W) || m_pairs > CNT_MAX) ? 1 : 0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_total", 32'(out_total), 32'(exp_total));
    check("out_count", 32'(out_count), 32'(exp_count));
    check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    if (poke_in) begin
      in_a     = 6'd7;
      in_b     = 6'd7;
      in_last  = 1'b1;
      in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_total", 32'(out_total), 32'(exp_total));
      check("hold_count", 32'(out_count), 32'(exp_count));
      check("hold_ovf", 32'(out_ovf), 32'(exp_ovf));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    m_sum     = 0;
    m_pairs   = 0;
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_total_clr", 32'(out_total), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_term1", 32'(o_add_term1), 32'd0);
    check("rst_term2", 32'(o_add_term2), 32'd0);
    check("rst_total", 32'(out_total), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);

    // Single pair with adder carry out: 63+63 = 126.
    send_pair(63, 63, 1'b1);
    collect(0, 1'b0);

    // Three-pair frame totalling 97.
    send_pair(1, 2, 1'b0);
    send_pair(10, 20, 1'b0);
    send_pair(63, 1, 1'b1);
    collect(1, 1'b0);

    // Accumulator wrap: 378 mod 256 = 122 with ovf, then a clean frame.
    for (int i = 0; i < 3; i++) send_pair(63, 63, i == 2);
    collect(0, 1'b0);
    send_pair(1, 1, 1'b1);
    collect(0, 1'b0);

    // Backpressure with in_valid held high during OUT; next frame must start from zero.
    send_pair(40, 33, 1'b1);
    collect(5, 1'b1);
    send_pair(2, 3, 1'b1);
    collect(0, 1'b0);

    // Mid-frame reset discards the frame.
    send_pair(9, 9, 1'b0);
    send_pair(8, 8, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_sum   = 0;
    m_pairs = 0;
    check("mrst_total", 32'(out_total), 32'd0);
    check("mrst_count", 32'(out_count), 32'd0);
    check("mrst_term1", 32'(o_add_term1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_no_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
    end
    send_pair(5, 6, 1'b1);
    collect(0, 1'b0);

    // Counter boundary: exactly CNT_MAX pairs, then one more which saturates and flags ovf.
    for (int i = 0; i < CNT_MAX; i++) send_pair(0, 0, i == CNT_MAX - 1);
    collect(0, 1'b0);
    for (int i = 0; i < CNT_MAX + 1; i++) send_pair(0, 0, i == CNT_MAX);
    collect(0, 1'b0);

    // Randomized frames against the model.
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int p = 0; p < n; p++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_pair($urandom_range(0, 63), $urandom_range(0, 63), p == n - 1);
      end
      collect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
